// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS ID-stage constants, ID/EX layout and control decode
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int IDEX_WB_LSB      = 0;
  localparam int IDEX_M_LSB       = 2;
  localparam int IDEX_EX_LSB      = 5;
  localparam int IDEX_PC_LSB      = 9;
  localparam int IDEX_RS_DATA_LSB = 41;
  localparam int IDEX_RT_DATA_LSB = 73;
  localparam int IDEX_IMM_LSB     = 105;
  localparam int IDEX_RT_LSB      = 137;
  localparam int IDEX_RD_LSB      = 142;
  localparam int IDEX_W           = 147;

  localparam logic [IDEX_W-1:0] IDEX_BUBBLE = '0;

  // wb={MemtoReg,RegWrite}, m={Branch,MemRead,MemWrite}, ex={ALUOp,RegDst,ALUSrc}
  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.wb = 2'b01; c.m = 3'b000; c.ex = {ALUOP_FUNCT, 1'b1, 1'b0}; end
      OP_LW:    begin c.wb = 2'b11; c.m = 3'b010; c.ex = {ALUOP_ADD, 1'b0, 1'b1}; end
      OP_SW:    begin c.wb = 2'b00; c.m = 3'b001; c.ex = {ALUOP_ADD, 1'b0, 1'b1}; end
      OP_BEQ:   begin c.wb = 2'b00; c.m = 3'b100; c.ex = {ALUOP_SUB, 1'b0, 1'b0}; end
      OP_ADDI:  begin c.wb = 2'b01; c.m = 3'b000; c.ex = {ALUOP_ADD, 1'b0, 1'b1}; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 32x32 register file, $0 hardwired, write-through reads
module decode_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [32];
  logic        wr_live;

  assign wr_live = wr_en && (wr_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Bypass the array so a same-cycle writeback is seen by the decoding instruction
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (wr_live && (wr_addr == rs_addr)) rs_data = wr_data;
    if (wr_live && (wr_addr == rt_addr)) rt_data = wr_data;
    if (rs_addr == 5'd0) rs_data = '0;
    if (rt_addr == 5'd0) rt_data = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: control decode, load-use hazard, ID/EX register
module decode_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       if_id,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  output logic              stall,
  output logic [IDEX_W-1:0] id_ex,
  output logic [4:0]        id_ex_rs
);

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext, pc4;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  load_rt;
  logic        load_pending, hazard;
  ctrl_t       ctrl;

  assign opcode  = if_id[31:26];
  assign rs      = if_id[25:21];
  assign rt      = if_id[20:16];
  assign rd      = if_id[15:11];
  assign imm_ext = {{16{if_id[15]}}, if_id[15:0]};
  assign pc4     = if_id[63:32];
  assign ctrl    = decode_ctrl(opcode);

  decode_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wr_en   (wb_reg_write),
    .wr_addr (wb_rd),
    .wr_data (wb_data)
  );

  assign load_rt      = id_ex[IDEX_RT_LSB +: 5];
  assign load_pending = id_ex[IDEX_M_LSB + 1] && (load_rt != 5'd0);
  assign hazard       = load_pending &&
                        ((load_rt == rs) || ((load_rt == rt) && reads_rt(opcode)));
  // A taken branch squashes this instruction anyway, so holding IF/ID would be wrong
  assign stall        = hazard && !flush && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex    <= IDEX_BUBBLE;
      id_ex_rs <= '0;
    end else if (flush || stall) begin
      id_ex    <= IDEX_BUBBLE;
      id_ex_rs <= '0;
    end else begin
      id_ex    <= {rd, rt, imm_ext, rt_data, rs_data, pc4, ctrl.ex, ctrl.m, ctrl.wb};
      id_ex_rs <= rs;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage with reference model
module tb_decode_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  if_id;
  logic         wb_reg_write;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         flush;
  logic         stall;
  logic [146:0] id_ex;
  logic [4:0]   id_ex_rs;

  int checks = 0;
  int failures = 0;

  decode_stage dut (
    .clk          (clk),
    .reset        (reset),
    .if_id        (if_id),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .stall        (stall),
    .id_ex        (id_ex),
    .id_ex_rs     (id_ex_rs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [146:0] act, input logic [146:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: what the execute stage should see, kept as named fields
  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rt, rd, rs;
  } stage_t;

  logic [31:0] mregs [32];
  stage_t      exp_st;
  bit          model_valid = 0;

  function automatic logic [146:0] pack(input stage_t s);
    logic [146:0] v;
    v = '0;
    v[1:0]     = s.wb;
    v[4:2]     = s.m;
    v[8:5]     = s.ex;
    v[40:9]    = s.pc4;
    v[72:41]   = s.rsd;
    v[104:73]  = s.rtd;
    v[136:105] = s.imm;
    v[141:137] = s.rt;
    v[146:142] = s.rd;
    return v;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_reg_write && wb_rd == idx) return wb_data;
    return mregs[idx];
  endfunction

  function automatic logic model_stall();
    logic [5:0] op;
    logic       uses_rt;
    op = if_id[31:26];
    uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    if (reset || flush) return 1'b0;
    if (!exp_st.m[1] || exp_st.rt == 0) return 1'b0;
    return (exp_st.rt == if_id[25:21]) || (uses_rt && exp_st.rt == if_id[20:16]);
  endfunction

  always @(posedge clk) begin
    stage_t nxt;
    nxt = '{default: '0};
    if (reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      model_valid = 1;
    end else begin
      if (!flush && !model_stall()) begin
        case (if_id[31:26])
          6'h00: begin nxt.wb = 2'b01; nxt.m = 3'b000; nxt.ex = 4'b1010; end
          6'h23: begin nxt.wb = 2'b11; nxt.m = 3'b010; nxt.ex = 4'b0001; end
          6'h2B: begin nxt.wb = 2'b00; nxt.m = 3'b001; nxt.ex = 4'b0001; end
          6'h04: begin nxt.wb = 2'b00; nxt.m = 3'b100; nxt.ex = 4'b0100; end
          6'h08: begin nxt.wb = 2'b01; nxt.m = 3'b000; nxt.ex = 4'b0001; end
          default: ;
        endcase
        nxt.pc4 = if_id[63:32];
        nxt.rs  = if_id[25:21];
        nxt.rt  = if_id[20:16];
        nxt.rd  = if_id[15:11];
        nxt.rsd = mread(if_id[25:21]);
        nxt.rtd = mread(if_id[20:16]);
        nxt.imm = {{16{if_id[15]}}, if_id[15:0]};
      end
      if (wb_reg_write && wb_rd != 0) mregs[wb_rd] = wb_data;
    end
    exp_st = nxt;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_id_ex", id_ex, pack(exp_st));
      chk("model_id_ex_rs", {142'd0, id_ex_rs}, {142'd0, exp_st.rs});
      chk("model_stall", {146'd0, stall}, {146'd0, model_stall()});
    end
  end

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic fl, input logic rst);
    if_id = {pc4, instr};
    wb_reg_write = we;
    wb_rd = wrd;
    wb_data = wd;
    flush = fl;
    reset = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(32'h0, 32'h0, 0, 0, 0, 0, 1);
    tick();
    tick();
    chk("reset_id_ex", id_ex, '0);
    chk("reset_id_ex_rs", {142'd0, id_ex_rs}, '0);
    chk("reset_stall", {146'd0, stall}, '0);

    drive(32'h0, 32'h4, 1, 5'd5, 32'h1234, 0, 0);
    tick();
    drive(32'h00A01820, 32'h8, 0, 0, 0, 0, 0);
    tick();
    chk("wb_read_rsdata", {115'd0, id_ex[72:41]}, 147'h1234);
    chk("wb_read_wb", {145'd0, id_ex[1:0]}, 147'b01);
    chk("wb_read_ex", {143'd0, id_ex[8:5]}, 147'b1010);
    chk("wb_read_rd", {142'd0, id_ex[146:142]}, 147'd3);
    chk("wb_read_rs", {142'd0, id_ex_rs}, 147'd5);

    drive(32'h00A01820, 32'hC, 1, 5'd5, 32'hBEEF, 0, 0);
    tick();
    chk("writethrough_rsdata", {115'd0, id_ex[72:41]}, 147'hBEEF);

    drive(32'h00000020, 32'h10, 1, 5'd0, 32'hFFFF, 0, 0);
    tick();
    chk("r0_same_cycle", {115'd0, id_ex[72:41]}, '0);
    drive(32'h00000020, 32'h14, 0, 0, 0, 0, 0);
    tick();
    chk("r0_read_after", {115'd0, id_ex[72:41]}, '0);

    drive(32'h8C22FFFC, 32'h40, 0, 0, 0, 0, 0);
    tick();
    chk("lw_imm", {115'd0, id_ex[136:105]}, 147'hFFFFFFFC);
    chk("lw_memread", {146'd0, id_ex[3]}, 147'd1);
    chk("lw_wb", {145'd0, id_ex[1:0]}, 147'b11);
    chk("lw_ex", {143'd0, id_ex[8:5]}, 147'b0001);
    chk("lw_rt", {142'd0, id_ex[141:137]}, 147'd2);
    chk("lw_pc4", {115'd0, id_ex[40:9]}, 147'h40);

    drive(32'h00432020, 32'h44, 0, 0, 0, 0, 0);
    chk("loaduse_stall", {146'd0, stall}, 147'd1);
    tick();
    chk("loaduse_bubble", {138'd0, id_ex[8:0]}, '0);
    drive(32'h00432020, 32'h44, 0, 0, 0, 0, 0);
    chk("loaduse_release", {146'd0, stall}, '0);
    tick();
    chk("loaduse_add_wb", {145'd0, id_ex[1:0]}, 147'b01);
    chk("loaduse_add_rd", {142'd0, id_ex[146:142]}, 147'd4);

    drive(32'h8C22FFFC, 32'h48, 0, 0, 0, 0, 0);
    tick();
    drive(32'h00432020, 32'h4C, 0, 0, 0, 1, 0);
    chk("flush_no_stall", {146'd0, stall}, '0);
    tick();
    chk("flush_bubble", id_ex, '0);

    drive(32'h8C22FFFC, 32'h50, 0, 0, 0, 0, 0);
    tick();
    drive(32'hACE20000, 32'h54, 0, 0, 0, 0, 0);
    chk("sw_rt_stall", {146'd0, stall}, 147'd1);
    tick();
    drive(32'h8C22FFFC, 32'h58, 0, 0, 0, 0, 0);
    tick();
    drive(32'h20A20001, 32'h5C, 0, 0, 0, 0, 0);
    chk("addi_rt_no_stall", {146'd0, stall}, '0);
    tick();
    drive(32'h8C20FFFC, 32'h60, 0, 0, 0, 0, 0);
    tick();
    drive(32'h00002020, 32'h64, 0, 0, 0, 0, 0);
    chk("lw_r0_no_stall", {146'd0, stall}, '0);
    tick();

    drive(32'hFC221234, 32'h68, 0, 0, 0, 0, 0);
    tick();
    chk("unknown_ctrl", {138'd0, id_ex[8:0]}, '0);
    chk("unknown_imm", {115'd0, id_ex[136:105]}, 147'h1234);

    drive(32'h0, 32'h6C, 1, 5'd7, 32'h77, 0, 0);
    tick();
    drive(32'h8C22FFFC, 32'h70, 0, 0, 0, 0, 0);
    tick();
    drive(32'h00432020, 32'h74, 0, 0, 0, 0, 1);
    chk("reset_hazard_stall", {146'd0, stall}, '0);
    tick();
    chk("midreset_id_ex", id_ex, '0);
    chk("midreset_id_ex_rs", {142'd0, id_ex_rs}, '0);
    drive(32'h00E51820, 32'h78, 0, 0, 0, 0, 0);
    tick();
    chk("midreset_r7", {115'd0, id_ex[72:41]}, '0);
    chk("midreset_r5", {115'd0, id_ex[104:73]}, '0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
